// File: rtl/axis_align_pkg.sv
// Shared types and byte-lane constants for the AXI-Stream head aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_align_pkg;

  // Aligner control states: waiting for a first beat, merging beats, emitting spill.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    FLUSH = 2'd2
  } align_state_t;

  // Bits per byte lane, and the matching shift so byte counts scale to bit counts.
  localparam int BYTE_W     = 8;
  localparam int BYTE_SHIFT = 3;

endpackage

// File: rtl/keep_offset_encoder.sv
// Decodes a tkeep vector into trailing-zero count, popcount and contiguity flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; it only observes the keep lanes.
module keep_offset_encoder #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] i_keep,
  output logic [CNT_W-1:0]      o_tz,
  output logic [CNT_W-1:0]      o_pop,
  output logic                  o_contig
);

  logic [DATA_WIDTH-1:0] w_norm;

  // Scan lanes top-down so the lowest set lane wins the trailing-zero count; a zero keep reports DATA_WIDTH.
  always_comb begin
    o_tz  = CNT_W'(DATA_WIDTH);
    o_pop = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (i_keep[i]) begin
        o_tz = CNT_W'(i);
      end
      o_pop = o_pop + CNT_W'(i_keep[i]);
    end
  end

  // With the trailing zeros stripped, a single run of ones is 2^n-1, which has no bit in common with itself+1.
  assign w_norm   = i_keep >> o_tz;
  assign o_contig = (i_keep != '0) && ((w_norm & (w_norm + DATA_WIDTH'(1))) == '0);

endmodule

// File: rtl/axis_head_aligner.sv
// Realigns each AXI-Stream packet so its first valid byte lands on lane 0.
// Latency: output register loads on the accept that completes a beat; first beat is held one beat.
// Backpressure: s_tready follows the output register (free or draining); one stall cycle for a spill beat.
module axis_head_aligner
  import axis_align_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OFFSET_W   = $clog2(DATA_WIDTH)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [DATA_WIDTH*8-1:0]   s_tdata,
  input  logic [DATA_WIDTH-1:0]     s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [DATA_WIDTH*8-1:0]   m_tdata,
  output logic [DATA_WIDTH-1:0]     m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      err_keep
);

  localparam int DBITS = DATA_WIDTH * BYTE_W;
  // Byte counts reach DATA_WIDTH itself, so they need one bit more than an offset.
  localparam int CNT_W = OFFSET_W + 1;
  // Residue plus last-beat count can reach 2*DATA_WIDTH.
  localparam int TOT_W = CNT_W + 1;
  localparam int SHW   = CNT_W + BYTE_SHIFT;
  localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_WIDTH);

  // Keep mask with the lowest n lanes set, saturating at a full beat.
  function automatic logic [DATA_WIDTH-1:0] ones_mask(input logic [TOT_W-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = (TOT_W'(i) < n);
    end
    return m;
  endfunction

  // Control and datapath state.
  align_state_t          r_state;
  align_state_t          w_state_nxt;
  logic [OFFSET_W-1:0]   r_off;
  logic [CNT_W-1:0]      r_rcnt;
  logic [CNT_W-1:0]      r_fcnt;
  logic [DBITS-1:0]      r_res;
  logic                  r_m_vld;
  logic [DBITS-1:0]      r_m_dat;
  logic [DATA_WIDTH-1:0] r_m_keep;
  logic                  r_m_last;
  logic                  r_err;

  // Keep decode of the beat on the input.
  logic [CNT_W-1:0]      w_tz;
  logic [CNT_W-1:0]      w_pop;
  logic                  w_contig;
  logic [OFFSET_W-1:0]   w_tz_off;

  // Handshake and datapath wires.
  logic                  w_out_free;
  logic                  w_s_rdy;
  logic                  w_accept;
  logic                  w_bad;
  logic [OFFSET_W-1:0]   w_off_cur;
  logic [DBITS-1:0]      w_shr;
  logic [DBITS-1:0]      w_shl;
  logic [DBITS-1:0]      w_merged;
  logic [TOT_W-1:0]      w_total;

  // Next-value controls produced by the FSM decode.
  logic                  w_load;
  logic [DBITS-1:0]      w_ld_dat;
  logic [DATA_WIDTH-1:0] w_ld_keep;
  logic                  w_ld_last;
  logic                  w_res_ld;
  logic [DBITS-1:0]      w_res_nxt;
  logic                  w_first_ld;
  logic [CNT_W-1:0]      w_rcnt_nxt;
  logic                  w_fcnt_ld;
  logic [CNT_W-1:0]      w_fcnt_nxt;

  keep_offset_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_keep_enc (
    .i_keep   (s_tkeep),
    .o_tz     (w_tz),
    .o_pop    (w_pop),
    .o_contig (w_contig)
  );

  // A zero keep has no first byte; it is processed as offset 0.
  assign w_tz_off   = (w_tz >= DW_CNT) ? '0 : w_tz[OFFSET_W-1:0];

  assign w_out_free = !r_m_vld || m_tready;
  assign w_s_rdy    = aresetn && (r_state != FLUSH) && w_out_free;
  assign w_accept   = s_tvalid && w_s_rdy;
  assign s_tready   = w_s_rdy;

  // The first beat sets the offset; later beats reuse the stored one.
  assign w_off_cur  = (r_state == IDLE) ? w_tz_off : r_off;
  assign w_shr      = s_tdata >> (SHW'(w_off_cur) << BYTE_SHIFT);
  // A residue of a full beat (offset 0) shifts the new beat entirely out, giving the one-beat delay.
  assign w_shl      = s_tdata << (SHW'(r_rcnt) << BYTE_SHIFT);
  assign w_merged   = r_res | w_shl;
  assign w_total    = TOT_W'(r_rcnt) + TOT_W'(w_pop);

  // Malformed keep: broken or empty run, or a middle beat that is not full.
  assign w_bad      = !w_contig || ((r_state == MERGE) && !s_tlast && (s_tkeep != '1));

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ld_dat    = '0;
    w_ld_keep   = '0;
    w_ld_last   = 1'b0;
    w_res_ld    = 1'b0;
    w_res_nxt   = '0;
    w_first_ld  = 1'b0;
    w_rcnt_nxt  = '0;
    w_fcnt_ld   = 1'b0;
    w_fcnt_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_first_ld = 1'b1;
          w_rcnt_nxt = DW_CNT - CNT_W'(w_tz_off);
          if (s_tlast) begin
            w_load    = 1'b1;
            w_ld_dat  = w_shr;
            w_ld_keep = ones_mask(TOT_W'(w_pop));
            w_ld_last = 1'b1;
          end else begin
            w_res_ld    = 1'b1;
            w_res_nxt   = w_shr;
            w_state_nxt = MERGE;
          end
        end
      end
      MERGE: begin
        if (w_accept) begin
          w_load    = 1'b1;
          w_ld_dat  = w_merged;
          w_ld_keep = '1;
          w_res_ld  = 1'b1;
          w_res_nxt = w_shr;
          if (s_tlast) begin
            if (w_total <= TOT_W'(DATA_WIDTH)) begin
              w_ld_keep   = ones_mask(w_total);
              w_ld_last   = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_fcnt_ld   = 1'b1;
              w_fcnt_nxt  = CNT_W'(w_total - TOT_W'(DATA_WIDTH));
              w_state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_ld_dat    = r_res;
          w_ld_keep   = ones_mask(TOT_W'(r_fcnt));
          w_ld_last   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Residue, offset and spill-count bookkeeping.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_off  <= '0;
      r_rcnt <= '0;
      r_fcnt <= '0;
      r_res  <= '0;
    end else begin
      if (w_first_ld) begin
        r_off  <= w_tz_off;
        r_rcnt <= w_rcnt_nxt;
      end
      if (w_res_ld) begin
        r_res <= w_res_nxt;
      end
      if (w_fcnt_ld) begin
        r_fcnt <= w_fcnt_nxt;
      end
    end
  end

  // Output register: load a completed beat, otherwise drop valid once the sink takes it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_vld  <= 1'b0;
      r_m_dat  <= '0;
      r_m_keep <= '0;
      r_m_last <= 1'b0;
    end else if (w_load) begin
      r_m_vld  <= 1'b1;
      r_m_dat  <= w_ld_dat;
      r_m_keep <= w_ld_keep;
      r_m_last <= w_ld_last;
    end else if (m_tready) begin
      r_m_vld  <= 1'b0;
    end
  end

  // One-cycle error pulse for each accepted malformed beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad;
    end
  end

  assign m_tvalid = r_m_vld;
  assign m_tdata  = r_m_dat;
  assign m_tkeep  = r_m_keep;
  assign m_tlast  = r_m_last;
  assign err_keep = r_err;

endmodule

// File: doc/axis_head_aligner.md
AXIS_HEAD_ALIGNER -- requirements
Module: axis_head_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bytes per beat; data is DATA_WIDTH*8 bits, keep is DATA_WIDTH bits.
REQ-002 SHALL have parameter OFFSET_W, default $clog2(DATA_WIDTH): width of byte-offset and byte-count quantities.
REQ-003 SHALL have one clock and a synchronous, active-low reset: aclk (input, 1 bit, all logic on rising edge) and aresetn (input, 1 bit, synchronous active-low reset).
REQ-004 SHALL have ports, in this order after clock and reset:
- s_tdata  in  DATA_WIDTH*8  input payload
- s_tkeep  in  DATA_WIDTH  byte enables, lane 0 = bits [7:0]
- s_tlast  in  1  last beat of packet
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  DATA_WIDTH*8  aligned payload
- m_tkeep  out  DATA_WIDTH  contiguous from lane 0
- m_tlast  out  1  last beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- err_keep  out  1  one-cycle pulse on a malformed keep

Function
REQ-005 SHALL make offset O equal to the number of trailing zero keep bits of the first beat of each packet; the first beat is the first accepted beat after reset or after a beat with s_tlast.
REQ-006 SHALL realign each packet so its first valid byte appears on lane 0; every output beat except the last SHALL have m_tkeep all ones.
REQ-007 SHALL require input middle beats to have full keep, and the last input beat (if not the first) to have contiguous keep from lane 0 with k valid bytes.
REQ-008 SHALL hold a residue of R = DATA_WIDTH-O bytes from the first beat, shifted right by O bytes.
REQ-009 SHALL use the following rule on each later accepted beat B:
- output = residue OR (B shifted left R bytes), truncated to DATA_WIDTH bytes
- new residue = B shifted right O bytes
REQ-010 SHALL treat O=0 generically: R=DATA_WIDTH, giving one beat of delay with no bypass path.
REQ-011 SHALL handle the last input beat with total = R+k as follows:
- total ≤ DATA_WIDTH: emit one beat with m_tlast=1 and keep = total ones from lane 0
- otherwise: emit a full beat with m_tlast=0, then a FLUSH beat with keep = total-DATA_WIDTH ones and m_tlast=1
REQ-012 SHALL handle a single-beat packet (first beat with s_tlast) by emitting one beat: data shifted right O bytes, keep = popcount ones, m_tlast=1.
REQ-013 SHALL use FSM states IDLE, MERGE and FLUSH:
- IDLE→MERGE on accepting a non-last first beat
- IDLE stays IDLE on accepting a single-beat packet
- MERGE→IDLE on a last beat that fits in one output beat
- MERGE→FLUSH on a last beat that spills
- FLUSH→IDLE when the residue beat is loaded into the output register
REQ-014 SHALL register all outputs: m_* become valid the cycle after the accept that completes a beat, and hold stable while m_tvalid=1 and m_tready=0.
REQ-015 SHALL drive s_tready = (state != FLUSH) AND (m_tvalid=0 OR m_tready=1); a first beat that produces no output SHALL still obey this rule.
REQ-016 SHALL load the output register on an accept in MERGE, or on a single-beat packet in IDLE, in the same cycle an older beat drains; this gives full throughput with no bubbles within a packet.
REQ-017 SHALL deassert s_tready for exactly one cycle in FLUSH when m_tready=1; a back-to-back next packet SHALL then be accepted the following cycle.
REQ-018 SHALL pulse err_keep for one cycle on any of these; data is still processed with the computed O/k:
- non-contiguous keep
- zero keep
- a middle beat without full keep

Reset
REQ-019 SHALL, when aresetn=0 on a rising edge, set state=IDLE, m_tvalid=0, m_tlast=0, m_tkeep=0, err_keep=0 and the residue to 0; m_tdata SHALL be 0.
REQ-020 SHALL drive s_tready=0 while aresetn=0.
REQ-021 SHALL, on reset mid-packet or in FLUSH, discard the partial packet; the next accepted beat is a first beat.

Structure
REQ-022 SHALL place the state enum (IDLE, MERGE, FLUSH) and byte-count helper constants in shared package axis_align_pkg.
REQ-023 SHALL place keep decoding in combinational sub-module keep_offset_encoder, with these outputs:
- trailing-zero count
- popcount
- contiguity flag
REQ-024 SHALL perform byte shifts in 8-bit-lane multiples only; there is no bit-granular shifting.

Verification (DATA_WIDTH=16)
REQ-025 SHALL cover the offset-3 spill case: first keep 0xFFF8, middle keep 0xFFFF, last keep 0x00FF, bytes numbered 0..36 → three beats, keep 0xFFFF, 0xFFFF, 0x001F, bytes 0..36 in order, m_tlast on the third.
REQ-026 SHALL cover the single-beat case: keep 0xFFF0 with s_tlast → one beat, keep 0x0FFF, input lanes 4..15 on lanes 0..11, m_tlast=1.
REQ-027 SHALL cover the offset-0 case: full, full, last keep 0x0001 → beats keep 0xFFFF, 0xFFFF, 0x0001, data unchanged, one-cycle FLUSH stall on s_tready.
REQ-028 SHALL cover backpressure: m_tready=0 for 5 cycles mid-packet → s_tready=0 throughout, m_tdata/m_tkeep stable, no byte lost or duplicated.
REQ-029 SHALL cover reset during FLUSH: aresetn=0 for one cycle → next cycle m_tvalid=0, and the following packet (keep 0xFF00, last) yields keep 0x00FF.
REQ-030 SHALL cover a malformed keep: keep 0xF0F0 on a first beat → err_keep pulses one cycle, O=4.
